axi_full_slave_ram: RTL
=======================

AXI_FULL_SLAVE_RAM -- requirements
Module: axi_full_slave_ram

Interface
REQ-001 Params: C_S_BASE_ADDR=32'h40000000 (byte base of window); C_S_AXI_ID_WIDTH=1; C_S_AXI_ADDR_WIDTH=32; C_S_AXI_DATA_WIDTH=32; C_S_MEM_DEPTH=256 (words, power of 2).
REQ-002 S_AXI_ACLK in 1 -- the only clock; S_AXI_ARESET in 1 -- synchronous, active-high reset.
REQ-003 AW channel: S_AXI_AWID in ID, S_AXI_AWADDR in ADDR, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-004 W channel: S_AXI_WDATA in DATA, S_AXI_WSTRB in DATA/8, S_AXI_WLAST in 1, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-005 B channel: S_AXI_BID out ID, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-006 AR channel: S_AXI_ARID in ID, S_AXI_ARADDR in ADDR, S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-007 R channel: S_AXI_RID out ID, S_AXI_RDATA out DATA, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-008 No USER, LOCK, CACHE, PROT or QOS ports; the master's copies of these are left unconnected.

Function
REQ-009 FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA. One transaction outstanding at a time.
REQ-010 IDLE: AWREADY=1 and ARREADY=1 combinationally only in IDLE; ARREADY is forced to 0 whenever AWVALID=1, so writes win a same-cycle collision.
REQ-011 AW handshake: latch ID, word index (AWADDR-C_S_BASE_ADDR)>>log2(DATA/8), and beat count AWLEN+1; go to WR_DATA next cycle.
REQ-012 Error flag set at address acceptance if any of: AWBURST!=INCR; AWSIZE!=log2(DATA/8); start below base; start word + AWLEN >= C_S_MEM_DEPTH. Same rules apply to AR.
REQ-013 WR_DATA: WREADY=1. Each W beat writes only the WSTRB-enabled bytes to mem[index], then index+1. Errored bursts consume beats without writing.
REQ-014 The internal beat counter reaching AWLEN+1 ends the burst, not WLAST; WLAST!=(final beat) on any beat sets the error flag.
REQ-015 After the final beat, go to WR_RESP: BVALID=1, BID=latched ID, BRESP=SLVERR(2'b10) if error else OKAY(2'b00). Hold until BREADY, then go to IDLE.
REQ-016 AR handshake: latch ID, index and count; RD_DATA starts on the next cycle with RVALID=1.
REQ-017 RD_DATA: RDATA=mem[index] (0 if errored), RRESP per error flag, RLAST=1 on beat ARLEN+1, RID=latched ID. RDATA/RRESP/RLAST stay stable while RVALID && !RREADY.
REQ-018 On each RVALID && RREADY the block advances to the next beat, which is back-to-back throughput. The beat with RLAST set returns the FSM to IDLE.
REQ-019 AWLEN/ARLEN=0 is a single beat with WLAST/RLAST on that beat. The index never wraps, because range is checked up front.
REQ-020 Memory contents are not cleared by reset.

Reset
REQ-021 While S_AXI_ARESET=1 at a clock edge: FSM=IDLE; AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST=0; BRESP, RRESP, BID, RID, RDATA=0; counters and error flag=0.
REQ-022 Reset mid-burst abandons the transaction; no B response is issued for it. Partially written words remain in memory.
REQ-023 The first cycle after reset deasserts is IDLE with AWREADY=ARREADY=1.

Structure
REQ-024 Shared package axi_full_pkg holds: the FSM state encoding, RESP_OKAY/RESP_SLVERR, BURST_INCR, and the clogb2 width function shared with the master.
REQ-025 Sub-module axi_slave_ram: single-port word array with per-byte write enables and asynchronous read, depth C_S_MEM_DEPTH. All handshake logic stays in the top module.

Verification
REQ-026 Write 16 beats of data 0..15, AWADDR=0x40000064, AWLEN=15, BREADY=1 -> words 25..40 hold 0..15; BVALID one cycle after the 16th beat; BRESP=0.
REQ-027 Read the same burst with RREADY=1 -> 16 consecutive beats of 0..15, RLAST only on beat 16, RRESP=0, ARREADY low throughout.
REQ-028 RREADY toggled 1/0 every cycle -> RDATA/RLAST held during stalls; all 16 beats delivered in order.
REQ-029 AWVALID and ARVALID both asserted in the same IDLE cycle -> AW accepted and AR held off until the write response completes, then AR accepted.
REQ-030 AWADDR=0x40000400 (word 256), AWLEN=3 -> 4 beats accepted, memory unchanged, BRESP=2'b10. Write with WSTRB=4'b0011 -> only the low 2 bytes change.
REQ-031 Reset asserted on the 5th beat of a 16-beat write -> all outputs 0 next cycle; IDLE after release; a following read of words 25..28 returns beats 1..4.

Source files
------------

// File: rtl/axi_full_pkg.sv
// Shared AXI4 definitions for the full-protocol RAM slave and its matching master.
// Holds the FSM encoding, response/burst codes and the clogb2 width helper.
package axi_full_pkg;

    typedef logic [1:0] axi_state_t;

    localparam axi_state_t ST_IDLE    = 2'd0;
    localparam axi_state_t ST_WR_DATA = 2'd1;
    localparam axi_state_t ST_WR_RESP = 2'd2;
    localparam axi_state_t ST_RD_DATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Bits needed to index 'value' entries: clogb2(4)=2, clogb2(256)=8.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v >>= 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Single-port word array with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module axi_slave_ram
    import axi_full_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned ADDR_W    = clogb2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/axi_full_slave_ram.sv
// AXI4 full slave fronting a word RAM: INCR bursts only, one transaction at a time.
// Bad bursts are still fully handshaken but never touch memory and answer SLVERR.
module axi_full_slave_ram
    import axi_full_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_MEM_DEPTH      = 256,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_BASE_ADDR = 32'h40000000
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,

    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = clogb2(STRB_W);
    localparam int unsigned IDX_W    = clogb2(C_S_MEM_DEPTH);

    localparam logic [2:0]  SIZE_FULL = 3'(ADDR_LSB);
    localparam logic [AW:0] DEPTH_EXT = {1'b0, AW'(C_S_MEM_DEPTH)};

    // Range is checked on the last word of the burst so the index can never wrap.
    function automatic logic req_error(
        input logic [AW-1:0] addr,
        input logic [7:0]    len,
        input logic [2:0]    size,
        input logic [1:0]    burst
    );
        logic [AW-1:0] w_word;
        logic [AW:0]   w_last_word;
        w_word      = (addr - C_S_BASE_ADDR) >> ADDR_LSB;
        w_last_word = {1'b0, w_word} + {{(AW - 7){1'b0}}, len};
        return (burst != BURST_INCR) || (size != SIZE_FULL) ||
               (addr < C_S_BASE_ADDR) || (w_last_word >= DEPTH_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [AW-1:0] addr);
        logic [AW-1:0] w_word;
        w_word = (addr - C_S_BASE_ADDR) >> ADDR_LSB;
        return w_word[IDX_W-1:0];
    endfunction

    axi_state_t                  r_state;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic [IDX_W-1:0]            r_idx;
    logic [7:0]                  r_len;
    logic [7:0]                  r_beat;
    logic                        r_err;

    logic                          w_in_idle;
    logic                          w_final;
    logic                          w_wbeat;
    logic                          w_wlast_bad;
    logic [STRB_W-1:0]             w_mem_we;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_mem_rdata;

    assign w_in_idle   = (r_state == ST_IDLE) && !S_AXI_ARESET;
    assign w_final     = (r_beat == r_len);
    assign w_wbeat     = S_AXI_WVALID && S_AXI_WREADY;
    assign w_wlast_bad = w_wbeat && (S_AXI_WLAST != w_final);

    always_comb begin
        w_mem_we = '0;
        if (w_wbeat && !r_err && !w_wlast_bad && !S_AXI_ARESET) begin
            w_mem_we = S_AXI_WSTRB;
        end
    end

    assign S_AXI_AWREADY = w_in_idle;
    assign S_AXI_ARREADY = w_in_idle && !S_AXI_AWVALID;
    assign S_AXI_WREADY  = (r_state == ST_WR_DATA);

    assign S_AXI_BVALID  = (r_state == ST_WR_RESP);
    assign S_AXI_BID     = r_id;
    assign S_AXI_BRESP   = (S_AXI_BVALID && r_err) ? RESP_SLVERR : RESP_OKAY;

    // R outputs derive only from registered state, so they hold steady under backpressure.
    assign S_AXI_RVALID  = (r_state == ST_RD_DATA);
    assign S_AXI_RID     = r_id;
    assign S_AXI_RRESP   = (S_AXI_RVALID && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RLAST   = S_AXI_RVALID && w_final;
    assign S_AXI_RDATA   = (S_AXI_RVALID && !r_err) ? w_mem_rdata : '0;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (S_AXI_AWVALID) begin
                        r_id    <= S_AXI_AWID;
                        r_idx   <= word_index(S_AXI_AWADDR);
                        r_len   <= S_AXI_AWLEN;
                        r_beat  <= '0;
                        r_err   <= req_error(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
                        r_state <= ST_WR_DATA;
                    end else if (S_AXI_ARVALID) begin
                        r_id    <= S_AXI_ARID;
                        r_idx   <= word_index(S_AXI_ARADDR);
                        r_len   <= S_AXI_ARLEN;
                        r_beat  <= '0;
                        r_err   <= req_error(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (S_AXI_WVALID) begin
                        r_idx  <= r_idx + 1'b1;
                        r_beat <= r_beat + 1'b1;
                        if (w_wlast_bad) begin
                            r_err <= 1'b1;
                        end
                        if (w_final) begin
                            r_state <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (w_final) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axi_slave_ram #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .DEPTH      (C_S_MEM_DEPTH)
    ) u_ram (
        .i_clk   (S_AXI_ACLK),
        .i_we    (w_mem_we),
        .i_addr  (r_idx),
        .i_wdata (S_AXI_WDATA),
        .o_rdata (w_mem_rdata)
    );

endmodule
